// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: host-side write port of the UART transmitter.
//
// Handshake: a byte is transferred on a rising clock edge where the master
// holds write_data_enable=1 and the slave presents write_data_available=1.
// write_data_available is a registered flag (no combinational path from the
// inputs), so a master may sample it one cycle ahead and rely on it.
// An enable while write_data_available=0 is silently dropped.
// busy reports that a frame is on the wire or a byte is still queued.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] write_data;
  logic                 write_data_enable;
  logic                 write_data_available;
  logic                 busy;

  modport master (
    output write_data,
    output write_data_enable,
    input  write_data_available,
    input  busy
  );

  modport slave (
    input  write_data,
    input  write_data_enable,
    output write_data_available,
    output busy
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with a one-entry holding
// register and CTS (active-low) flow control sampled at frame boundaries.
// Optional parity bit: define UART_TX_PARITY_EN to compile in the PARITY
// state (polarity chosen by PARITY_ODD); without it frames go DATA -> STOP.
// FSM state is exposed on dbg_state_o.
module uart_tx_cfg #(
  parameter int CLOCK_HZ   = 12500000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  uart_tx_cfg_if.slave      wr,
  input  logic              cts,
  output logic              tx,
  output logic [2:0]        dbg_state_o
);

  localparam int DIVISOR = CLOCK_HZ / BAUD;
  localparam int CNT_W   = $clog2(DIVISOR + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVISOR - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // Reject configurations the bit counters and baud counter cannot handle.
  if (DIVISOR < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_illegal
    $error("uart_tx_cfg: illegal parameter combination");
  end

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic write_accept;
  logic cnt_wrap;
  logic start_ok;
  logic load;

  // Next-state logic: holding register write, baud counter and frame FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    tx_d         = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d        = par_q;
`endif
    load         = 1'b0;

    // A write can never coincide with a drain: draining needs hold_valid_q=1,
    // accepting needs hold_valid_q=0.
    write_accept = wr.write_data_enable && !hold_valid_q;
    cnt_wrap     = (cnt_q == CNT_LAST);
    start_ok     = hold_valid_q && !cts;

    if (write_accept) begin
      hold_d       = wr.write_data;
      hold_valid_d = 1'b1;
    end

    if (state_q != S_IDLE) begin
      cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start_ok) load = 1'b1;
      end
      S_START: begin
        if (cnt_wrap) begin
          state_d = S_DATA;
          bit_d   = 4'd0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (cnt_wrap) begin
          if (bit_q == DATA_LAST) begin
            bit_d = 4'd0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_wrap) begin
          state_d = S_STOP;
          bit_d   = 4'd0;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_wrap) begin
          if (bit_q == STOP_LAST) begin
            // Frame boundary: chain straight into the next start bit if a
            // byte is queued and the host is ready, otherwise go idle.
            if (start_ok) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start: move the queued byte into the shifter and drive the start bit.
    if (load) begin
      shift_d      = hold_q;
      hold_valid_d = 1'b0;
      tx_d         = 1'b0;
      cnt_d        = '0;
      bit_d        = 4'd0;
      state_d      = S_START;
`ifdef UART_TX_PARITY_EN
      par_d        = (^hold_q) ^ (PARITY_ODD != 0);
`endif
    end
  end

  // State registers; reset drives the line idle and empties the holding register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= 4'd0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign tx                      = tx_q;
  assign wr.write_data_available = !hold_valid_q;
  assign wr.busy                 = (state_q != S_IDLE) || hold_valid_q;
  assign dbg_state_o             = state_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed bench for uart_tx_cfg at DIVISOR=16.
// Default build checks 8N1; with UART_TX_PARITY_EN it checks 7O2.
module tb_uart_tx_cfg;

  localparam int CLK_HZ = 1600;
  localparam int BAUD   = 100;
  localparam int DIV    = 16;
`ifdef UART_TX_PARITY_EN
  localparam int DB  = 7;
  localparam int SB  = 2;
  localparam int P   = 1;
  localparam int ODD = 1;
`else
  localparam int DB  = 8;
  localparam int SB  = 1;
  localparam int P   = 0;
  localparam int ODD = 0;
`endif
  localparam int NB = 1 + DB + P + SB;

  // ---------------- clock / reset ----------------
  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic       cts     = 1'b1;
  logic       tx;
  logic [2:0] dbg_state;
  int         cyc     = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  uart_tx_cfg_if #(.DATA_BITS(DB)) wr ();

  uart_tx_cfg #(
    .CLOCK_HZ  (CLK_HZ),
    .BAUD      (BAUD),
    .DATA_BITS (DB),
    .STOP_BITS (SB),
    .PARITY_ODD(ODD)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr         (wr.slave),
    .cts        (cts),
    .tx         (tx),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DB-1:0] exp_q[$];
  int            start_q[$];
  bit            mon_en   = 1'b0;
  bit            mon_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Expected line levels for one frame, bit 0 = start bit.
  function automatic logic [15:0] frame_bits(input logic [DB-1:0] d);
    logic [15:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DB; i++) f[1 + i] = d[i];
    if (P == 1) f[1 + DB] = (ODD == 1) ? ~^d : ^d;
    return f;
  endfunction

  // ---------------- monitor ----------------
  // Waits for a start bit, pops the expected byte and checks every cycle of
  // every bit; a reset during the frame abandons it.
  initial begin : monitor
    logic [15:0]   f;
    logic [DB-1:0] d;
    bit            aborted;
    int            wrong;
    forever begin
      @(negedge clock);
      if (mon_en && reset_n && tx === 1'b0) begin
        mon_busy = 1'b1;
        start_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got start bit expected idle at cycle %0d", cyc);
          f = '1;
        end else begin
          d = exp_q.pop_front();
          f = frame_bits(d);
        end
        aborted = 1'b0;
        for (int b = 0; b < NB && !aborted; b++) begin
          wrong = 0;
          for (int c = 0; c < DIV; c++) begin
            if (b != 0 || c != 0) @(negedge clock);
            if (!reset_n) begin
              aborted = 1'b1;
              break;
            end
            if (tx !== f[b]) wrong++;
          end
          if (!aborted) check($sformatf("frame_bit%0d_wrong_cycles", b), 32'(wrong), 32'd0);
        end
        mon_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_byte(input logic [DB-1:0] d, input bit exp_accept, input string name);
    @(negedge clock);
    check({name, "_available"}, 32'(wr.write_data_available), 32'(exp_accept));
    wr.write_data        = d;
    wr.write_data_enable = 1'b1;
    if (exp_accept) exp_q.push_back(d);
    @(negedge clock);
    wr.write_data_enable = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit, output int waited);
    waited = 0;
    while ((wr.busy !== 1'b0 || mon_busy) && waited < limit) begin
      @(negedge clock);
      waited++;
    end
    check({name, "_idle_timeout"}, 32'(waited < limit), 32'd1);
  endtask

  task automatic quiet(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) bad++;
    end
    check({name, "_tx_high_cycles_bad"}, 32'(bad), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    int w;
    int t0;
    wr.write_data        = '0;
    wr.write_data_enable = 1'b0;

    // Reset held while the host is writing.
    #1 reset_n = 1'b0;
    cts = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      wr.write_data_enable = 1'b1;
      wr.write_data        = DB'(8'hA5);
    end
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_available", 32'(wr.write_data_available), 32'd1);
    check("reset_busy", 32'(wr.busy), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    @(negedge clock);
    wr.write_data_enable = 1'b0;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    quiet("post_reset", 40);
    check("post_reset_busy", 32'(wr.busy), 32'd0);
    check("post_reset_frames", 32'(start_q.size()), 32'd0);

    // Single frame 0xA5.
    start_q.delete();
    write_byte(DB'(8'hA5), 1'b1, "single");
    check("single_tx_before_start", 32'(tx), 32'd1);
    check("single_available_low", 32'(wr.write_data_available), 32'd0);
    check("single_busy", 32'(wr.busy), 32'd1);
    @(negedge clock);
    check("single_start_bit", 32'(tx), 32'd0);
    check("single_available_back", 32'(wr.write_data_available), 32'd1);
    wait_idle("single", NB * DIV + 20, w);
    check("single_frames", 32'(start_q.size()), 32'd1);
    if (start_q.size() == 1) check("single_length", 32'(cyc - start_q[0]), 32'(NB * DIV));
    check("single_busy_end", 32'(wr.busy), 32'd0);

    // Back-to-back: second byte queued mid-frame, third rejected.
    start_q.delete();
    write_byte(DB'(8'h55), 1'b1, "b2b_first");
    repeat (4) @(negedge clock);
    write_byte(DB'(8'h0F), 1'b1, "b2b_second");
    write_byte(DB'(8'hAA), 1'b0, "b2b_third");
    wait_idle("b2b", 2 * NB * DIV + 40, w);
    check("b2b_frames", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2) check("b2b_gap", 32'(start_q[1] - start_q[0]), 32'(NB * DIV));
    check("b2b_no_drop", 32'(exp_q.size()), 32'd0);

    // Flow control: held by cts, released, then cts raised mid-frame.
    cts = 1'b1;
    start_q.delete();
    write_byte(DB'(8'h3C), 1'b1, "fc");
    quiet("fc_held", 20);
    check("fc_busy", 32'(wr.busy), 32'd1);
    check("fc_available", 32'(wr.write_data_available), 32'd0);
    cts = 1'b0;
    @(negedge clock);
    check("fc_start_bit", 32'(tx), 32'd0);
    repeat (3 * DIV) @(negedge clock);
    cts = 1'b1;
    wait_idle("fc", NB * DIV + 20, w);
    check("fc_frames", 32'(start_q.size()), 32'd1);
    cts = 1'b0;

    // Parity-sensitive byte.
    start_q.delete();
    write_byte(DB'(8'h41), 1'b1, "p41");
    wait_idle("p41", NB * DIV + 20, w);
    check("p41_frames", 32'(start_q.size()), 32'd1);

    // Reset during data bit 3 of 0x00 with 0x33 queued behind it.
    start_q.delete();
    write_byte(DB'(8'h00), 1'b1, "rst_first");
    @(negedge clock);
    t0 = cyc;
    write_byte(DB'(8'h33), 1'b1, "rst_held");
    while (cyc - t0 < 4 * DIV + DIV / 2) @(negedge clock);
    check("rst_pre_tx", 32'(tx), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_available", 32'(wr.write_data_available), 32'd1);
    check("rst_busy", 32'(wr.busy), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    quiet("rst_after", 30);
    check("rst_busy_after", 32'(wr.busy), 32'd0);
    check("rst_frames", 32'(start_q.size()), 32'd1);
    write_byte(DB'(8'hFF), 1'b1, "rst_fresh");
    wait_idle("rst_fresh", NB * DIV + 20, w);
    check("rst_fresh_frames", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2) check("rst_fresh_length", 32'(cyc - start_q[1]), 32'(NB * DIV));

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
